// File: rtl/u409_pkg.sv
// Shared definitions for the U409 termination arbiter.
// - tack_state_t / ST_*: sequencer state encoding, kept as plain constants so
//   older U409 blocks that compare raw state codes keep working.
// - REQ_*: requester bit positions on tack_req. Bit 0 has the highest priority.
// - TIMEOUT_CLKS_DEF: default CLK40 cycles from _TS to forced termination.
package u409_pkg;

  typedef logic [2:0] tack_state_t;

  localparam tack_state_t ST_IDLE    = 3'd0;
  localparam tack_state_t ST_WAIT    = 3'd1;
  localparam tack_state_t ST_ASSERT  = 3'd2;
  localparam tack_state_t ST_NEGATE  = 3'd3;
  localparam tack_state_t ST_RELEASE = 3'd4;

  localparam int unsigned REQ_ROM   = 0;
  localparam int unsigned REQ_IRQ   = 1;
  localparam int unsigned REQ_RTC   = 2;
  localparam int unsigned REQ_FLASH = 3;
  localparam int unsigned REQ_AC    = 4;
  localparam int unsigned REQ_CIA   = 5;

  localparam int unsigned NUM_REQ_DEF      = 8;
  localparam int unsigned TIMEOUT_CLKS_DEF = 125;
  localparam int unsigned CNT_W_DEF        = 7;

endpackage

// File: rtl/u409_tack_arbiter_if.sv
// Bus-side bundle of the U409 termination arbiter.
// - master: the 68040 bus side and the requesting sources (drive ts_n,
//   agnus_space, tack_req, tci_mask, err_clr; observe line controls/status).
// - slave:  the arbiter itself.
// Signals:
//   ts_n        transfer start, active low
//   agnus_space current cycle targets chip RAM/registers, freezes the timeout
//   tack_req    per-source termination request
//   tci_mask    per-source cacheable flag (1 holds _TCI negated)
//   err_clr     clears the sticky status bits
//   tack_oe     enable for the _TACK/_TBI/_TCI drivers
//   tack_out    value for _TACK and _TBI
//   tci_out     value for _TCI
//   grant       one-hot winner of the current termination
//   cycle_act   a bus cycle is open and not yet terminated
//   timeout_err sticky: a cycle ended by timeout
//   overlap_err sticky: a request was dropped
interface u409_tack_arbiter_if #(
  parameter int unsigned NUM_REQ = 8
) ();

  logic               ts_n;
  logic               agnus_space;
  logic [NUM_REQ-1:0] tack_req;
  logic [NUM_REQ-1:0] tci_mask;
  logic               err_clr;

  logic               tack_oe;
  logic               tack_out;
  logic               tci_out;
  logic [NUM_REQ-1:0] grant;
  logic               cycle_act;
  logic               timeout_err;
  logic               overlap_err;

  modport master (
    output ts_n, agnus_space, tack_req, tci_mask, err_clr,
    input  tack_oe, tack_out, tci_out, grant, cycle_act, timeout_err, overlap_err
  );

  modport slave (
    input  ts_n, agnus_space, tack_req, tci_mask, err_clr,
    output tack_oe, tack_out, tci_out, grant, cycle_act, timeout_err, overlap_err
  );

endinterface

// File: rtl/u409_prio_onehot.sv
// Fixed-priority one-hot picker, purely combinational.
// Ports:
//   req    request vector, bit 0 highest priority
//   win    one-hot lowest set bit of req (all zero when req is zero)
//   any    at least one request is set
//   losers a request other than the winner is set (it will be dropped)
module u409_prio_onehot
  import u409_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] win,
  output logic               any,
  output logic               losers
);

  // req & -req isolates the lowest set bit.
  assign win    = req & (~req + NUM_REQ'(1));
  assign any    = |req;
  assign losers = |(req & ~win);

endmodule

// File: rtl/u409_tack_arbiter.sv
// Sole owner of the shared 68040 termination lines _TACK/_TBI/_TCI in U409.
// Sources raise one-clock (or level) requests; one request per bus cycle is
// granted by fixed priority and turned into an assert/negate/release pulse.
// Unanswered cycles are terminated by an internal timeout.
// Ports:
//   CLK40_IN         40MHz bus clock, rising edge
//   DELAYED_TACK_RST asynchronous active-low reset
//   bus              arbiter side of u409_tack_arbiter_if (requests, status)
//   tack_n/tbi_n/tci_n  tri-stated termination lines
module u409_tack_arbiter
  import u409_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
  // 2**CNT_W must exceed TIMEOUT_CLKS
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                 CLK40_IN,
  input  logic                 DELAYED_TACK_RST,
  u409_tack_arbiter_if.slave   bus,
  output wire                  tack_n,
  output wire                  tbi_n,
  output wire                  tci_n
);

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tack_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               cycle_act_q, cycle_act_d;
  logic               tci_q, tci_d;
  logic               ts_pend_q, ts_pend_d;
  logic               timeout_err_q, timeout_err_d;
  logic               overlap_err_q, overlap_err_d;
  logic               set_tmo, set_ovl;

  logic [NUM_REQ-1:0] win;
  logic               req_any;
  logic               req_losers;

  u409_prio_onehot #(
    .NUM_REQ (NUM_REQ)
  ) u_prio (
    .req    (bus.tack_req),
    .win    (win),
    .any    (req_any),
    .losers (req_losers)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    cycle_act_d = cycle_act_q;
    tci_d       = tci_q;
    ts_pend_d   = ts_pend_q;
    set_tmo     = 1'b0;
    set_ovl     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A request may arrive before the sampled _TS; it terminates that cycle.
        if (req_any) begin
          state_d = ST_ASSERT;
          grant_d = win;
          tci_d   = |(bus.tci_mask & win);
          set_ovl = req_losers;
          cnt_d   = '0;
          if (!bus.ts_n) begin
            cycle_act_d = 1'b1;
          end
        end else if (!bus.ts_n) begin
          state_d     = ST_WAIT;
          cycle_act_d = 1'b1;
          cnt_d       = CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (req_any) begin
          state_d = ST_ASSERT;
          grant_d = win;
          tci_d   = |(bus.tci_mask & win);
          set_ovl = req_losers;
          cnt_d   = '0;
        end else if (!bus.agnus_space && (cnt_q == TMO_CNT)) begin
          // Forced termination: no grant, _TCI asserted.
          state_d = ST_ASSERT;
          grant_d = '0;
          tci_d   = 1'b0;
          set_tmo = 1'b1;
          cnt_d   = '0;
        end else if (!bus.ts_n) begin
          // New cycle started without termination: restart the timeout.
          cnt_d = CNT_ONE;
        end else if (!bus.agnus_space && (cnt_q < TMO_CNT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ASSERT: begin
        state_d     = ST_NEGATE;
        cycle_act_d = 1'b0;
        set_ovl     = req_any;
        if (!bus.ts_n) begin
          ts_pend_d = 1'b1;
        end
      end

      ST_NEGATE: begin
        state_d = ST_RELEASE;
        set_ovl = req_any;
        if (!bus.ts_n) begin
          ts_pend_d = 1'b1;
        end
      end

      ST_RELEASE: begin
        set_ovl   = req_any;
        grant_d   = '0;
        ts_pend_d = 1'b0;
        if (ts_pend_q || !bus.ts_n) begin
          state_d     = ST_WAIT;
          cycle_act_d = 1'b1;
          cnt_d       = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        grant_d     = '0;
        cycle_act_d = 1'b0;
        ts_pend_d   = 1'b0;
      end
    endcase

    // Set wins over clear.
    timeout_err_d = set_tmo | (timeout_err_q & ~bus.err_clr);
    overlap_err_d = set_ovl | (overlap_err_q & ~bus.err_clr);
  end

  always_ff @(posedge CLK40_IN or negedge DELAYED_TACK_RST) begin
    if (!DELAYED_TACK_RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      grant_q       <= '0;
      cycle_act_q   <= 1'b0;
      tci_q         <= 1'b1;
      ts_pend_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      cycle_act_q   <= cycle_act_d;
      tci_q         <= tci_d;
      ts_pend_q     <= ts_pend_d;
      timeout_err_q <= timeout_err_d;
      overlap_err_q <= overlap_err_d;
    end
  end

  // Line controls decode straight from the state register so that reset
  // releases the lines without waiting for a clock edge.
  assign bus.tack_oe     = (state_q == ST_ASSERT) || (state_q == ST_NEGATE);
  assign bus.tack_out    = (state_q != ST_ASSERT);
  assign bus.tci_out     = (state_q == ST_ASSERT) ? tci_q : 1'b1;
  assign bus.grant       = grant_q;
  assign bus.cycle_act   = cycle_act_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.overlap_err = overlap_err_q;

  assign tack_n = bus.tack_oe ? bus.tack_out : 1'bz;
  assign tbi_n  = bus.tack_oe ? bus.tack_out : 1'bz;
  assign tci_n  = bus.tack_oe ? bus.tci_out  : 1'bz;

endmodule

// File: tb/tb_u409_tack_arbiter.sv
// Directed bench for u409_tack_arbiter: inputs change 1ns after a rising
// edge, outputs are checked at that same point (away from the edge).
`timescale 1ns/1ps
module tb_u409_tack_arbiter;
  import u409_pkg::*;

  logic clk;
  logic rst_n;
  wire  tack_n;
  wire  tbi_n;
  wire  tci_n;
  int   n_chk;
  int   n_pass;
  int   k;

  u409_tack_arbiter_if #(.NUM_REQ(8)) bus ();

  u409_tack_arbiter #(
    .NUM_REQ      (8),
    .TIMEOUT_CLKS (125),
    .CNT_W        (7)
  ) dut (
    .CLK40_IN         (clk),
    .DELAYED_TACK_RST (rst_n),
    .bus              (bus),
    .tack_n           (tack_n),
    .tbi_n            (tbi_n),
    .tci_n            (tci_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.ts_n        = 1'b1;
    bus.agnus_space = 1'b0;
    bus.tack_req    = '0;
    bus.tci_mask    = '0;
    bus.err_clr     = 1'b0;
    #25;
    chk("rst_oe",      bus.tack_oe, 0);
    chk("rst_out",     bus.tack_out, 1);
    chk("rst_tci",     bus.tci_out, 1);
    chk("rst_grant",   bus.grant, 0);
    chk("rst_cyc",     bus.cycle_act, 0);
    chk("rst_tmo_err", bus.timeout_err, 0);
    chk("rst_ovl_err", bus.overlap_err, 0);
    rst_n = 1'b1;
    steps(2);

    // ROM request, cacheable: TSn driven at edge 0, request at edge 3.
    bus.ts_n = 1'b0;                         // edge 0
    step();                                  // edge 1: sampled
    bus.ts_n = 1'b1;
    chk("rom_cyc_open", bus.cycle_act, 1);
    steps(2);                                // edge 3
    bus.tack_req = 8'h01 << REQ_ROM;
    bus.tci_mask = 8'h01;
    step();                                  // edge 4: ASSERT
    bus.tack_req = '0;
    chk("rom_tack",    bus.tack_out, 0);
    chk("rom_tci",     bus.tci_out, 1);
    chk("rom_grant",   bus.grant, 8'h01);
    chk("rom_oe",      bus.tack_oe, 1);
    chk("rom_tack_n",  tack_n, 0);
    chk("rom_tbi_n",   tbi_n, 0);
    step();                                  // edge 5: NEGATE
    chk("rom_neg_out", bus.tack_out, 1);
    chk("rom_neg_oe",  bus.tack_oe, 1);
    chk("rom_neg_cyc", bus.cycle_act, 0);
    step();                                  // edge 6: RELEASE
    chk("rom_rel_oe",  bus.tack_oe, 0);
    chk("rom_rel_gnt", bus.grant, 8'h01);
    step();
    chk("rom_idle_gnt", bus.grant, 0);
    chk("rom_no_ovl",   bus.overlap_err, 0);

    // Simultaneous RTC and CIA: RTC wins, its mask bit is 0.
    bus.ts_n = 1'b0;
    step();
    bus.ts_n     = 1'b1;
    bus.tack_req = 8'h24;
    bus.tci_mask = 8'h20;
    step();
    bus.tack_req = '0;
    chk("sim_grant", bus.grant, 8'h04);
    chk("sim_tci",   bus.tci_out, 0);
    chk("sim_ovl",   bus.overlap_err, 1);
    step();                                  // NEGATE: new _TS arrives
    bus.ts_n = 1'b0;
    step();                                  // RELEASE
    bus.ts_n = 1'b1;
    step();
    chk("ts_latched_cyc", bus.cycle_act, 1);
    chk("ts_latched_oe",  bus.tack_oe, 0);
    bus.tack_req = 8'h01;
    step();
    bus.tack_req = '0;
    chk("ts_latched_gnt", bus.grant, 8'h01);
    steps(3);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("sim_clr", bus.overlap_err, 0);

    // Timeout with no requester.
    bus.ts_n = 1'b0;
    step();                                  // _TS sampled
    bus.ts_n = 1'b1;
    k = 0;
    while (bus.tack_out === 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("tmo_latency", k, 125);
    chk("tmo_err",     bus.timeout_err, 1);
    chk("tmo_grant",   bus.grant, 0);
    chk("tmo_tci",     bus.tci_out, 0);
    steps(3);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("tmo_clr", bus.timeout_err, 0);

    // Agnus space holds the counter well past the limit.
    bus.agnus_space = 1'b1;
    bus.ts_n        = 1'b0;
    step();
    bus.ts_n = 1'b1;
    steps(500);
    chk("agn_no_tack", bus.tack_out, 1);
    chk("agn_cyc",     bus.cycle_act, 1);
    bus.tack_req = 8'h01 << REQ_AC;
    step();
    bus.tack_req = '0;
    chk("agn_tack",  bus.tack_out, 0);
    chk("agn_grant", bus.grant, 8'h10);
    chk("agn_no_tmo", bus.timeout_err, 0);
    steps(3);
    bus.agnus_space = 1'b0;

    // Late request during NEGATE is dropped.
    bus.ts_n = 1'b0;
    step();
    bus.ts_n     = 1'b1;
    bus.tack_req = 8'h01;
    step();                                  // ASSERT
    bus.tack_req = '0;
    step();                                  // NEGATE
    bus.tack_req = 8'h01 << REQ_IRQ;
    step();                                  // RELEASE
    bus.tack_req = '0;
    chk("late_ovl",   bus.overlap_err, 1);
    chk("late_grant", bus.grant, 8'h01);
    step();
    chk("late_idle_out", bus.tack_out, 1);
    chk("late_idle_gnt", bus.grant, 0);
    step();
    chk("late_no_pulse", bus.tack_out, 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("late_clr", bus.overlap_err, 0);

    // Set beats clear on the same clock.
    bus.tack_req = 8'h03;
    bus.err_clr  = 1'b1;
    step();
    bus.tack_req = '0;
    bus.err_clr  = 1'b0;
    chk("set_wins", bus.overlap_err, 1);
    steps(3);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // Asynchronous reset in the middle of ASSERT.
    bus.tack_req = 8'h01;
    step();
    bus.tack_req = '0;
    chk("prerst_oe", bus.tack_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_oe",    bus.tack_oe, 0);
    chk("arst_out",   bus.tack_out, 1);
    chk("arst_grant", bus.grant, 0);
    #10;
    rst_n = 1'b1;
    steps(2);
    chk("arst_idle", bus.tack_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
